// File: rtl/req_flag_arbiter_if.sv
// rtl/req_flag_arbiter_if.sv - request/grant bundle between the requesters and req_flag_arbiter
interface req_flag_arbiter_if #(
    parameter int N = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic [N-1:0]  clr;
    logic          done;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_id;
    logic [N-1:0]  pending;
    logic          timeout;

    modport master (
        output req, clr, done,
        input  gnt, gnt_valid, gnt_id, pending, timeout
    );

    modport slave (
        input  req, clr, done,
        output gnt, gnt_valid, gnt_id, pending, timeout
    );
endinterface

// File: rtl/req_flag_arbiter.sv
// rtl/req_flag_arbiter.sv - round-robin arbiter over pending request flags (option: REQ_FLAG_ARBITER_TIMEOUT_EN)
module req_flag_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst,
    req_flag_arbiter_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    if (N < 2 || N > 16 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
        $error("req_flag_arbiter: parameter out of range");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  pending_q, pending_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic [IW-1:0] gnt_id_q, gnt_id_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          timeout_q, timeout_d;

    logic [IW-1:0] win;
    logic          any_pend;
    logic          holder_clr;
    logic          hit_limit;
    logic          release_w;
    logic          issue_en;
    logic [N-1:0]  issue;

    // Winner: first registered pending bit at or after ptr, wrapping modulo N
    always_comb begin
        logic [IW:0] sum;
        logic        found;
        win   = '0;
        found = 1'b0;
        sum   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            if (!found && pending_q[sum[IW-1:0]]) begin
                found = 1'b1;
                win   = sum[IW-1:0];
            end
        end
    end

    assign any_pend   = |pending_q;
    assign holder_clr = bus.clr[gnt_id_q];

`ifdef REQ_FLAG_ARBITER_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;

    assign hit_limit = (state_q == GRANT) && (hold_q == 8'(MAX_HOLD - 1));

    // Hold counter: restarts on every issue, counts cycles spent in GRANT
    always_comb begin
        hold_d = '0;
        if (issue_en) begin
            hold_d = '0;
        end else if (state_q == GRANT && !release_w) begin
            hold_d = hold_q + 8'd1;
        end
    end

    // Hold counter register
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign hit_limit = 1'b0;
`endif

    assign release_w = (state_q == GRANT) && (bus.done || holder_clr || hit_limit);
    assign issue_en  = any_pend && ((state_q == IDLE) || release_w);
    assign issue     = issue_en ? (N'(1) << win) : '0;

    // Next state: issue a new grant, drop to idle on release, or hold
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        ptr_d       = ptr_q;
        pending_d   = (pending_q | bus.req) & ~bus.clr & ~issue;
        // A forced release only counts when neither done nor cancel beat it
        timeout_d   = hit_limit && !bus.done && !holder_clr;
        if (issue_en) begin
            state_d     = GRANT;
            gnt_d       = issue;
            gnt_valid_d = 1'b1;
            gnt_id_d    = win;
            ptr_d       = (win == IW'(N - 1)) ? '0 : win + IW'(1);
        end else if (release_w) begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            gnt_id_d    = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            ptr_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            ptr_q       <= ptr_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.pending   = pending_q;
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_req_flag_arbiter.sv
// tb/tb_req_flag_arbiter.sv - randomized and directed checks of req_flag_arbiter against a reference model
module tb_req_flag_arbiter;
    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
`ifdef REQ_FLAG_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    req_flag_arbiter_if #(.N(N)) bus ();

    req_flag_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: holder index (-1 = idle), pointer, pending flags, hold age
    int       m_holder = -1;
    int       m_ptr    = 0;
    int       m_hold   = 0;
    bit [N-1:0] m_pend = '0;
    bit       m_to     = 1'b0;
    bit       chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on the same edge the DUT samples its inputs
    always @(posedge clk) begin : model
        int  w;
        int  idx;
        bit  lim, rel, to;
        if (!rst) begin
            m_pend   = '0;
            m_holder = -1;
            m_ptr    = 0;
            m_hold   = 0;
            m_to     = 1'b0;
            chk_en   = 1'b1;
        end else begin
            lim = TO_EN && (m_holder >= 0) && (m_hold == MAX_HOLD - 1);
            rel = (m_holder >= 0) && (bus.done || bus.clr[m_holder] || lim);
            to  = lim && !bus.done && !bus.clr[m_holder];
            w = -1;
            if (m_holder < 0 || rel) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (w < 0 && m_pend[idx]) w = idx;
                end
            end
            for (int i = 0; i < N; i++) begin
                m_pend[i] = (m_pend[i] | bus.req[i]) & ~bus.clr[i] & (i != w);
            end
            if (w >= 0) begin
                m_holder = w;
                m_ptr    = (w + 1) % N;
                m_hold   = 0;
            end else if (rel) begin
                m_holder = -1;
            end else if (m_holder >= 0) begin
                m_hold++;
            end
            m_to = to;
        end
    end

    // Per-cycle comparison of all DUT outputs against the model
    always @(negedge clk) begin : compare
        logic [N-1:0] exp_gnt;
        if (chk_en) begin
            exp_gnt = (m_holder >= 0) ? (N'(1) << m_holder) : '0;
            check("gnt",       32'(bus.gnt),       32'(exp_gnt));
            check("gnt_valid", 32'(bus.gnt_valid), 32'(m_holder >= 0));
            check("gnt_id",    32'(bus.gnt_id),    (m_holder >= 0) ? 32'(m_holder) : 32'd0);
            check("pending",   32'(bus.pending),   32'(m_pend));
            check("timeout",   32'(bus.timeout),   32'(m_to));
        end
    end

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] c, input logic d);
        bus.req  = r;
        bus.clr  = c;
        bus.done = d;
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] r, c;
        bus.req  = '0;
        bus.clr  = '0;
        bus.done = 1'b0;
        @(negedge clk);

        // Reset with random requests
        rst = 1'b0;
        drive(N'($urandom), '0, 1'b0);
        drive(N'($urandom), '0, 1'b0);
        check("rst_pending",   32'(bus.pending),   32'd0);
        check("rst_gnt",       32'(bus.gnt),       32'd0);
        check("rst_gnt_valid", 32'(bus.gnt_valid), 32'd0);
        check("rst_gnt_id",    32'(bus.gnt_id),    32'd0);
        check("rst_timeout",   32'(bus.timeout),   32'd0);
        rst = 1'b1;
        drive(4'b0100, '0, 1'b0);
        check("lat_pending", 32'(bus.pending), 32'h4);
        check("lat_gnt_t1",  32'(bus.gnt),     32'h0);
        drive('0, '0, 1'b0);
        check("lat_gnt_t2",  32'(bus.gnt),     32'h4);
        check("lat_gnt_id",  32'(bus.gnt_id),  32'd2);
        drive('0, '0, 1'b1);
        check("lat_idle",    32'(bus.gnt),     32'h0);

        // Round-robin sweep from a fresh pointer
        rst = 1'b0;
        drive('0, '0, 1'b0);
        rst = 1'b1;
        drive(4'b1111, '0, 1'b0);
        drive('0, '0, 1'b0);
        check("rr_0", 32'(bus.gnt), 32'h1);
        drive('0, '0, 1'b1);
        check("rr_1", 32'(bus.gnt), 32'h2);
        drive('0, '0, 1'b1);
        check("rr_2", 32'(bus.gnt), 32'h4);
        drive('0, '0, 1'b1);
        check("rr_3", 32'(bus.gnt), 32'h8);
        drive('0, '0, 1'b1);
        check("rr_idle", 32'(bus.gnt_valid), 32'd0);

        // Fairness: requester 0 hammers while 1 and 3 wait
        drive(4'b1011, '0, 1'b0);
        drive(4'b0001, '0, 1'b0);
        check("fair_0", 32'(bus.gnt_id), 32'd0);
        drive(4'b0001, '0, 1'b1);
        check("fair_1", 32'(bus.gnt_id), 32'd1);
        drive(4'b0001, '0, 1'b1);
        check("fair_3", 32'(bus.gnt_id), 32'd3);
        drive(4'b0001, '0, 1'b1);
        check("fair_0b", 32'(bus.gnt_id), 32'd0);
        drive('0, '0, 1'b1);

        // Clear beats request; cancel of the holder
        drive(4'b0010, 4'b0010, 1'b0);
        check("reqclr_pending", 32'(bus.pending), 32'h0);
        drive('0, '0, 1'b0);
        check("reqclr_gnt", 32'(bus.gnt), 32'h0);
        drive(4'b0100, '0, 1'b0);
        drive('0, '0, 1'b0);
        check("clr_hold_gnt", 32'(bus.gnt), 32'h4);
        drive('0, 4'b0100, 1'b0);
        check("clr_abort", 32'(bus.gnt), 32'h0);

        // Reset mid-grant
        drive(4'b1000, '0, 1'b0);
        drive('0, '0, 1'b0);
        drive(4'b0011, '0, 1'b0);
        check("mid_gnt",     32'(bus.gnt),     32'h8);
        check("mid_pending", 32'(bus.pending), 32'h3);
        rst = 1'b0;
        drive('0, '0, 1'b0);
        check("mid_rst_gnt",     32'(bus.gnt),     32'h0);
        check("mid_rst_pending", 32'(bus.pending), 32'h0);
        rst = 1'b1;
        drive(4'b0010, '0, 1'b0);
        check("post_rst_pending", 32'(bus.pending), 32'h2);
        drive('0, '0, 1'b0);
        check("post_rst_gnt", 32'(bus.gnt), 32'h2);
        drive('0, '0, 1'b1);

`ifdef REQ_FLAG_ARBITER_TIMEOUT_EN
        // Forced release after MAX_HOLD grant cycles
        drive(4'b0001, '0, 1'b0);
        drive('0, '0, 1'b0);
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            drive('0, '0, 1'b0);
            check("to_hold", 32'(bus.gnt), 32'h1);
        end
        drive('0, '0, 1'b0);
        check("to_release", 32'(bus.gnt),     32'h0);
        check("to_pulse",   32'(bus.timeout), 32'd1);
        drive('0, '0, 1'b0);
        check("to_pulse_end", 32'(bus.timeout), 32'd0);
        // done on the last allowed cycle is a normal release
        drive(4'b0001, '0, 1'b0);
        for (int i = 0; i < MAX_HOLD - 1; i++) drive('0, '0, 1'b0);
        drive('0, '0, 1'b1);
        check("to_done_gnt",   32'(bus.gnt),     32'h0);
        check("to_done_pulse", 32'(bus.timeout), 32'd0);
`else
        // Without the timeout option a grant holds indefinitely
        drive(4'b0001, '0, 1'b0);
        for (int i = 0; i < 21; i++) drive('0, '0, 1'b0);
        check("hold_gnt",     32'(bus.gnt),     32'h1);
        check("hold_timeout", 32'(bus.timeout), 32'd0);
        drive('0, '0, 1'b1);
        check("hold_release", 32'(bus.gnt),     32'h0);
`endif

        // Randomized traffic, checked every cycle by the compare process
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 249) != 0);
            for (int b = 0; b < N; b++) begin
                r[b] = ($urandom_range(0, 3) == 0);
                c[b] = ($urandom_range(0, 9) == 0);
            end
            drive(r, c, ($urandom_range(0, 2) == 0));
        end
        rst = 1'b1;
        drive('0, '0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/req_flag_arbiter.md
Name: req_flag_arbiter

Overview:
- Shares one resource between N requesters using round-robin arbitration.
- Each requester has a pending flag: a request pulse sets it, a clear pulse cancels it, and clear wins over request in the same cycle.
- The arbiter grants one pending requester at a time, holds the grant until the resource signals done, then moves to the next requester.
- Sits in front of shared units, for example a memory port or a shared ALU, in the GPU controller.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 16, grant-hold cycle limit; used only when TIMEOUT_EN is defined (2..255).

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous, active-low reset; sampled on posedge clk.
- req  input  N  per-requester request pulse; sets pending[i].
- clr  input  N  per-requester cancel; clears pending[i] and aborts an active grant to i.
- done  input  1  resource finished with current holder; meaningful only while gnt_valid=1.
- gnt  output  N  registered one-hot grant; all zero when idle.
- gnt_valid  output  1  registered; equals OR of gnt.
- gnt_id  output  $clog2(N)  index of holder; 0 when idle.
- pending  output  N  registered pending flags.
- timeout  output  1  one-cycle pulse on forced release; constant 0 without TIMEOUT_EN.

Behaviour:
- Reset (rst=0 at posedge): pending=0, gnt=0, gnt_valid=0, gnt_id=0, timeout=0, round-robin pointer ptr=0, state=IDLE, hold counter=0. Reset overrides everything, including mid-grant; no done is needed afterwards.
- Pending update each cycle: pending_next[i] = (pending[i] | req[i]) & ~clr[i] & ~issue[i]. issue[i] is 1 when i is selected as the next holder this cycle.
- Arbitration uses registered pending only, never raw req.
  - Winner = first set pending bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo wrap).
- States:
  - IDLE: if any pending bit is set, grant the winner at the next edge. Set gnt[w]=1, gnt_valid=1, gnt_id=w, clear pending[w], set ptr=(w+1) mod N, go to GRANT. Otherwise stay in IDLE. done is ignored in IDLE.
  - GRANT: hold gnt stable.
    - Release condition: done=1, or clr[gnt_id]=1, or (TIMEOUT_EN only) the hold counter reaches MAX_HOLD-1.
    - On release with another pending bit set, grant the next winner back-to-back: the new grant is visible at the next edge with no idle cycle.
    - On release with nothing pending, go to IDLE with gnt=0, gnt_valid=0, gnt_id=0.
- Latency:
  - req at cycle t -> pending at t+1 -> gnt at t+2 when the arbiter is idle.
  - done at cycle t -> next gnt or idle at t+1.
- Simultaneous events:
  - req[i] and clr[i] together: pending[i] is 0.
  - req from the current holder during GRANT: sets pending again; served after the others because of ptr.
  - clr[j] on a non-holder: clears pending[j] only.
  - done and clr[holder] together: treated as a single release.
- Pointer: advances only on issue, so every requester is granted within N grants of setting pending.

Optional Feature:
- Macro: REQ_FLAG_ARBITER_TIMEOUT_EN.
- When defined:
  - An 8-bit hold counter clears on each issue and increments each cycle in GRANT.
  - If done and clr[holder] are both absent when the counter equals MAX_HOLD-1, the arbiter force-releases; the next edge behaves as for done.
  - timeout=1 for exactly that one cycle, registered alongside the release.
  - done in the same cycle as the limit is a normal release with no timeout pulse.
- When undefined: no counter, grants hold indefinitely, timeout is tied to 0.

Test Plan:
- Reset: drive rst=0 for 2 cycles with random req → pending=0, gnt=0, gnt_valid=0, gnt_id=0, timeout=0. Then rst=1 with req=4'b0100 pulsed at t → pending=4'b0100 at t+1, gnt=4'b0100 and gnt_id=2 at t+2.
- Round-robin: pulse req=4'b1111 once, assert done one cycle after each grant → gnt sequence 0001, 0010, 0100, 1000, back-to-back, then idle.
- Fairness: requester 0 re-requests every cycle while 1 and 3 are pending → grant order 0, 1, 3, 0; no requester waits for more than N grants.
- Same-cycle req[1] and clr[1] → pending[1] stays 0 and no grant occurs. clr[2] while gnt=4'b0100 → gnt=0 the next cycle, or the next pending requester is granted.
- Reset mid-grant: rst=0 while gnt=4'b1000 and pending=4'b0011 → all outputs 0 at the next edge. After release, pulsing req[1] grants 1 first (ptr=0, no stale pending).
- TIMEOUT_EN, MAX_HOLD=4: grant with no done → release after 4 grant cycles with timeout=1 for one cycle. done on cycle 4 → no timeout pulse.
